rpn_stack_master_32_bit: RTL
============================

// Module: rpn_stack_master_32_bit
// PURPOSE
// - Initiator side of the 32-bit stack interface: drives push/pop/peek, consumes empty/full/data.
// - Evaluates a Reverse-Polish token stream using the attached stack.
// - Sits between a token source (valid/ready) and one 32-bit stack instance sharing Clk_In/Reset_In.
// - Stack updates on negedge; this block runs on posedge and samples stack data one posedge after a pop/peek.
// PARAMETERS
// - STACK_DEPTH  8  entries in the attached stack; must match the stack instance
// - CNT_W        4  width of internal occupancy counter; holds 0..STACK_DEPTH
// PORTS
// - Clk_In          in   1   clock; all state updates on posedge
// - Reset_In        in   1   reset, asynchronous, active-high
// - Tok_Valid_In    in   1   token valid
// - Tok_Ready_Out   out  1   token accepted on posedge when Valid&Ready
// - Tok_Type_In     in   2   00 operand, 01 operator, 10 result, 11 clear
// - Tok_Data_In     in   32  operand value; operator code in [2:0]
// - Stk_Push_Out    out  1   push strobe to stack
// - Stk_Pop_Out     out  1   pop strobe to stack
// - Stk_Peek_Out    out  1   peek strobe to stack
// - Stk_Data_Out    out  32  data to push
// - Stk_Data_In     in   32  stack read data; Z outside pop/peek
// - Stk_Empty_In    in   1   stack empty
// - Stk_Full_In     in   1   stack full
// - Result_Out      out  32  top-of-stack value from result token
// - Result_Valid_Out out 1   one-cycle pulse with Result_Out
// - Err_Overflow_Out out 1   sticky: operand dropped, stack full
// - Err_Underflow_Out out 1  sticky: operator/result with too few entries
// BEHAVIOUR
// - Reset: FSM=IDLE; Tok_Ready_Out=1; all strobes 0; Stk_Data_Out, Result_Out 0; Result_Valid_Out, Err_* 0; count 0.
// - Reset mid-operation aborts the sequence; no partial push issued afterwards.
// - Strobes are registered, high exactly one cycle; at most one strobe high per cycle.
// - Stk_Data_In sampled only in CAP_* states; never sampled when no pop/peek is pending.
// - Tok_Ready_Out=1 only in IDLE; token accepted on posedge when Valid&Ready.
// - FSM: IDLE, PUSH, POP_B, CAP_B, POP_A, CAP_A, EXEC, PEEK, CAP_R, CLR_POP, CLR_WAIT.
// - Operand: IDLE->PUSH (Push=1, data=token)->IDLE; 2 cycles. If count==STACK_DEPTH or Stk_Full_In, consumed, not pushed, Err_Overflow set.
// - Operator: needs count>=2, else consumed, stack untouched, Err_Underflow set.
//   IDLE->POP_B->CAP_B(B=data)->POP_A->CAP_A(A=data)->EXEC(Push result)->IDLE; 6 cycles.
// - Opcodes (A op B, A = deeper entry): 0 ADD, 1 SUB A-B, 2 MUL low 32 bits, 3 AND, 4 OR, 5 XOR; 6,7 push A unchanged, B discarded.
// - Arithmetic mod 2^32 unless RPN_SAT_EN; MUL always wraps.
// - Result: IDLE->PEEK->CAP_R->IDLE; Result_Out=data, Result_Valid pulses in the IDLE cycle after CAP_R; count unchanged.
//   Empty: Result_Out=0, Result_Valid still pulses, Err_Underflow set, no peek issued.
// - Clear: pop each 2 cycles (CLR_POP/CLR_WAIT) until count==0, then clear both Err_* and return IDLE.
//   Clear on empty stack: 1 cycle.
// - Count: +1 per push, -1 per pop; never wraps; sticky Err_* cleared only by reset or clear token.
// CONFIGURATION
// - RPN_SAT_EN defined: ADD/SUB signed saturating; clamp to 0x7FFFFFFF / 0x80000000 on overflow.
// - RPN_SAT_EN undefined: ADD/SUB wrap modulo 2^32. No port change either way.
// TESTING
// - Tokens 5, 7, ADD, result -> push 5, push 7, pop 7, pop 5, push 12; Result_Out=0x0000000C, count 1.
// - 10, 3, SUB, 4, MUL, result -> Result_Out=28; operator latency exactly 6 cycles Valid-to-Ready.
// - 9 operands into 8-deep stack -> 8 pushes; 9th dropped, Err_Overflow=1, Full stays 1; clear -> 8 pops, Empty=1, Err_* 0.
// - Operator with count 1 -> no strobes, Err_Underflow=1; result on empty -> Result_Out=0, pulse, no peek.
// - 0x7FFFFFFF, 1, ADD -> with RPN_SAT_EN 0x7FFFFFFF; without 0x80000000.
// - Reset asserted in CAP_A -> next cycle IDLE, Ready=1, no push strobe, all outputs 0.

Source files
------------

// File: rtl/rpn_stack_master_32_bit.sv
// rpn_stack_master_32_bit
//   Reverse-Polish evaluator that drives an external 32-bit stack. A token
//   stream (valid/ready) supplies operands, operators, result requests and
//   clear requests. This block keeps its own occupancy count and issues
//   single-cycle push/pop/peek strobes to the stack.
//
//   Build option: define RPN_SAT_EN to make ADD/SUB signed-saturating;
//   otherwise they wrap modulo 2^32. MUL always wraps.
//
// Ports
//   Clk_In, Reset_In         clock (posedge), asynchronous active-high reset
//   Tok_Valid_In/Ready_Out   token handshake, accepted on Valid & Ready
//   Tok_Type_In              00 operand, 01 operator, 10 result, 11 clear
//   Tok_Data_In              operand value, or opcode in [2:0]
//   Stk_Push/Pop/Peek_Out    registered one-cycle strobes to the stack
//   Stk_Data_Out             push data
//   Stk_Data_In              stack read data, valid while pop/peek is high
//   Stk_Empty_In/Full_In     stack status
//   Result_Out/Valid_Out     top-of-stack value, one-cycle valid pulse
//   Err_Overflow_Out         sticky: operand dropped on a full stack
//   Err_Underflow_Out        sticky: operator/result with too few entries
module rpn_stack_master_32_bit #(
  parameter int STACK_DEPTH = 8,
  parameter int CNT_W       = 4
) (
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic        Tok_Valid_In,
  output logic        Tok_Ready_Out,
  input  logic [1:0]  Tok_Type_In,
  input  logic [31:0] Tok_Data_In,
  output logic        Stk_Push_Out,
  output logic        Stk_Pop_Out,
  output logic        Stk_Peek_Out,
  output logic [31:0] Stk_Data_Out,
  input  logic [31:0] Stk_Data_In,
  input  logic        Stk_Empty_In,
  input  logic        Stk_Full_In,
  output logic [31:0] Result_Out,
  output logic        Result_Valid_Out,
  output logic        Err_Overflow_Out,
  output logic        Err_Underflow_Out
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_POP_B, S_CAP_B, S_POP_A, S_CAP_A, S_EXEC,
    S_PEEK, S_CAP_R, S_CLR_POP, S_CLR_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       opcode;
  logic [31:0]      opnd_a, opnd_b, peek_q;
  logic [31:0]      sum_w, dif_w, alu_y;

  assign Tok_Ready_Out = (state == S_IDLE);

  // A is the deeper entry, B the former top: result = A op B.
  always_comb begin
    sum_w = opnd_a + opnd_b;
    dif_w = opnd_a - opnd_b;
`ifdef RPN_SAT_EN
    // Signed overflow: operands agree (add) / differ (sub) in sign and the
    // result sign departs from A. Clamp toward A's sign.
    if ((opnd_a[31] == opnd_b[31]) && (sum_w[31] != opnd_a[31]))
      sum_w = opnd_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if ((opnd_a[31] != opnd_b[31]) && (dif_w[31] != opnd_a[31]))
      dif_w = opnd_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    alu_y = opnd_a;
    case (opcode)
      3'd0: alu_y = sum_w;
      3'd1: alu_y = dif_w;
      3'd2: alu_y = opnd_a * opnd_b;
      3'd3: alu_y = opnd_a & opnd_b;
      3'd4: alu_y = opnd_a | opnd_b;
      3'd5: alu_y = opnd_a ^ opnd_b;
      default: alu_y = opnd_a;
    endcase
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state             <= S_IDLE;
      count             <= '0;
      opcode            <= '0;
      opnd_a            <= '0;
      opnd_b            <= '0;
      peek_q            <= '0;
      Stk_Push_Out      <= 1'b0;
      Stk_Pop_Out       <= 1'b0;
      Stk_Peek_Out      <= 1'b0;
      Stk_Data_Out      <= '0;
      Result_Out        <= '0;
      Result_Valid_Out  <= 1'b0;
      Err_Overflow_Out  <= 1'b0;
      Err_Underflow_Out <= 1'b0;
    end else begin
      // Strobes and the result pulse are single-cycle by default.
      Stk_Push_Out     <= 1'b0;
      Stk_Pop_Out      <= 1'b0;
      Stk_Peek_Out     <= 1'b0;
      Result_Valid_Out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Tok_Valid_In) begin
            case (Tok_Type_In)
              2'b00: begin
                if ((count == CNT_FULL) || Stk_Full_In) begin
                  Err_Overflow_Out <= 1'b1;
                end else begin
                  Stk_Push_Out <= 1'b1;
                  Stk_Data_Out <= Tok_Data_In;
                  count        <= count + CNT_ONE;
                  state        <= S_PUSH;
                end
              end
              2'b01: begin
                if (count < CNT_TWO) begin
                  Err_Underflow_Out <= 1'b1;
                end else begin
                  opcode      <= Tok_Data_In[2:0];
                  Stk_Pop_Out <= 1'b1;
                  count       <= count - CNT_ONE;
                  state       <= S_POP_B;
                end
              end
              2'b10: begin
                // Either view of "empty" suppresses the peek.
                if ((count == '0) || Stk_Empty_In) begin
                  Result_Out        <= '0;
                  Result_Valid_Out  <= 1'b1;
                  Err_Underflow_Out <= 1'b1;
                end else begin
                  Stk_Peek_Out <= 1'b1;
                  state        <= S_PEEK;
                end
              end
              default: begin
                if (count == '0) begin
                  Err_Overflow_Out  <= 1'b0;
                  Err_Underflow_Out <= 1'b0;
                end else begin
                  Stk_Pop_Out <= 1'b1;
                  count       <= count - CNT_ONE;
                  state       <= S_CLR_POP;
                end
              end
            endcase
          end
        end
        S_PUSH: state <= S_IDLE;
        // Read data is valid while the pop strobe is high; it is captured
        // on the edge that enters the matching CAP_* state.
        S_POP_B: begin
          opnd_b <= Stk_Data_In;
          state  <= S_CAP_B;
        end
        S_CAP_B: begin
          Stk_Pop_Out <= 1'b1;
          count       <= count - CNT_ONE;
          state       <= S_POP_A;
        end
        S_POP_A: begin
          opnd_a <= Stk_Data_In;
          state  <= S_CAP_A;
        end
        S_CAP_A: begin
          Stk_Push_Out <= 1'b1;
          Stk_Data_Out <= alu_y;
          count        <= count + CNT_ONE;
          state        <= S_EXEC;
        end
        S_EXEC: state <= S_IDLE;
        S_PEEK: begin
          peek_q <= Stk_Data_In;
          state  <= S_CAP_R;
        end
        S_CAP_R: begin
          Result_Out       <= peek_q;
          Result_Valid_Out <= 1'b1;
          state            <= S_IDLE;
        end
        S_CLR_POP: state <= S_CLR_WAIT;
        S_CLR_WAIT: begin
          if (count == '0) begin
            Err_Overflow_Out  <= 1'b0;
            Err_Underflow_Out <= 1'b0;
            state             <= S_IDLE;
          end else begin
            Stk_Pop_Out <= 1'b1;
            count       <= count - CNT_ONE;
            state       <= S_CLR_POP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
